// File: rtl/data_mem.sv
// +----------------------------------------------------------------------------+
// | data_mem : word-addressed data memory with fixed-latency request/done      |
// |            handshake; DMEM_BYTE_ACCESS_EN adds sign-extending byte access. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_mem #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
`ifdef DMEM_BYTE_ACCESS_EN
  input  logic        byte_op,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W+1:0]   addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               write_q, write_d;
  logic               byte_q, byte_d;
  logic               done_q, done_d;
  logic               misalign_q, misalign_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mem_we;

  logic [31:0]        mem_q [DEPTH];

  logic               w_byte_op;
  logic               w_req;
  logic               w_misaligned;
  logic [IDX_W-1:0]   w_idx;
  logic [1:0]         w_lane;
  logic [31:0]        w_rd_word;
  logic [7:0]         w_rd_byte;
  logic [31:0]        w_wr_word;
  logic               unused_addr_hi;

`ifdef DMEM_BYTE_ACCESS_EN
  assign w_byte_op = byte_op;
`else
  assign w_byte_op = 1'b0;
`endif

  // Address bits above the array span are deliberately ignored (wrap-around).
  assign unused_addr_hi = ^addr[31:IDX_W+2];

  assign w_req        = mem_read | mem_write;
  assign w_misaligned = !w_byte_op && (addr[1:0] != 2'b00);
  assign w_idx        = addr_q[IDX_W+1:2];
  assign w_lane       = addr_q[1:0];
  assign w_rd_word    = mem_q[w_idx];
  assign w_rd_byte    = w_rd_word[{w_lane, 3'b000} +: 8];

  always_comb begin
    w_wr_word = wdata_q;
    if (byte_q) begin
      w_wr_word = w_rd_word;
      w_wr_word[{w_lane, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    byte_d     = byte_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_req) begin
          addr_d  = addr[IDX_W+1:0];
          wdata_d = wdata;
          write_d = mem_write;
          byte_d  = w_byte_op;
          if (w_misaligned) begin
            misalign_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (write_q) begin
            mem_we = 1'b1;
          end else if (byte_q) begin
            rdata_d = {{24{w_rd_byte[7]}}, w_rd_byte};
          end else begin
            rdata_d = w_rd_word;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      byte_q     <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      byte_q     <= byte_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      rdata_q    <= rdata_d;
    end
  end

  // Array has no reset; reset still suppresses a pending store.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[w_idx] <= w_wr_word;
    end
  end

  assign busy     = (state_q == WAIT);
  assign done     = done_q;
  assign misalign = misalign_q;
  assign rdata    = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: model predicts each response, monitor checks.
`default_nettype none

module tb_data_mem;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int MAXC  = 8000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
`ifdef DMEM_BYTE_ACCESS_EN
  logic        byte_op;
`endif
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;

  data_mem #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
`ifdef DMEM_BYTE_ACCESS_EN
    .byte_op   (byte_op),
`endif
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          mis;
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  bit          exp_busy [MAXC];
  logic [31:0] model_mem [int];
  int          widx[$];
  int          free_edge = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: resolves an accepted request into its future observable effect.
  task automatic model_accept(input int k, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, input bit b);
    int          idx;
    int          lane;
    logic [31:0] w;
    exp_t        e;
    idx  = int'((a >> 2) % DEPTH);
    lane = int'(a % 4);
    e.mis = 1'b0; e.rd = 1'b0; e.data = '0;
    if (!b && lane != 0) begin
      e.mis = 1'b1;
      e.cyc = k + 1;
      q.push_back(e);
      free_edge = k + 2;
      return;
    end
    for (int c = k + 1; c <= k + LAT; c++) if (c < MAXC) exp_busy[c] = 1'b1;
    free_edge = k + 2 + LAT;
    e.rd  = !wr;
    e.cyc = k + 1 + LAT;
    if (wr) begin
      if (b) begin
        w = model_mem[idx];
        w[lane*8 +: 8] = d[7:0];
      end else begin
        w = d;
      end
      if (!model_mem.exists(idx)) widx.push_back(idx);
      model_mem[idx] = w;
    end else begin
      w = model_mem[idx];
      if (b) e.data = {{24{w[lane*8+7]}}, w[lane*8 +: 8]};
      else   e.data = w;
    end
    q.push_back(e);
  endtask

  task automatic step(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input bit b);
    @(negedge clk); #1;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
`ifdef DMEM_BYTE_ACCESS_EN
    byte_op   = b;
`endif
    if ((rd || wr) && (cyc + 1 >= free_edge)) model_accept(cyc, wr, a, d, b);
  endtask

  task automatic idle_until_free();
    for (int i = 0; i < 50 && (cyc + 1 < free_edge); i++) step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic op(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit b);
    step(!wr, wr, a, d, b);
    step(1'b0, 1'b0, '0, '0, 1'b0);
    idle_until_free();
  endtask

  // Monitor
  bit          started = 1'b0;
  logic [31:0] last_rd = '0;
  exp_t        me;

  always @(negedge clk) begin
    if (reset) begin
      started = 1'b1;
      last_rd = '0;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_misalign", misalign, 0);
      check("reset_rdata", rdata, 0);
    end else if (started) begin
      if (cyc < MAXC) check("busy", busy, exp_busy[cyc]);
      check("done_and_misalign", done & misalign, 0);
      if (done || misalign) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", {30'b0, done, misalign}, 0);
        end else begin
          me = q.pop_front();
          check("pulse_cycle", cyc, me.cyc);
          check("pulse_kind_misalign", misalign, me.mis);
          if (done && me.rd) begin
            check("load_rdata", rdata, me.data);
            last_rd = me.data;
          end else begin
            check("rdata_hold", rdata, last_rd);
          end
        end
      end else begin
        check("rdata_hold", rdata, last_rd);
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          me = q.pop_front();
          check("missing_pulse", {30'b0, done, misalign}, me.mis ? 32'd1 : 32'd2);
        end
      end
    end
  end

  initial begin
    int          r;
    bit          b;
    bit          wr;
    bit          rd;
    int          idx;
    logic [1:0]  low;
    logic [31:0] a;
    int          k;

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
`ifdef DMEM_BYTE_ACCESS_EN
    byte_op = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    free_edge = cyc + 1;

    op(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    op(1'b0, 32'h10, '0, 1'b0);
    op(1'b0, 32'h12, '0, 1'b0);
    op(1'b0, 32'h10, '0, 1'b0);
    op(1'b1, 32'h0, 32'h11111111, 1'b0);
    op(1'b1, 32'h400, 32'h22222222, 1'b0);
    op(1'b0, 32'h0, '0, 1'b0);

    // Held requests: first accepted, those during WAIT dropped, next taken in done cycle.
    for (int i = 0; i < 2 * (LAT + 2); i++) step(1'b1, 1'b0, 32'h10, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0);
    idle_until_free();

    // Store aborted by reset one cycle before its access edge.
    @(negedge clk); #1;
    mem_write = 1'b1; addr = 32'h10; wdata = 32'h55555555;
    k = cyc;
    if (k + 1 < MAXC) exp_busy[k + 1] = 1'b1;
    @(negedge clk); #1;
    mem_write = 1'b0; reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    free_edge = cyc + 1;
    op(1'b0, 32'h10, '0, 1'b0);

`ifdef DMEM_BYTE_ACCESS_EN
    op(1'b1, 32'h20, 32'h00000000, 1'b0);
    op(1'b1, 32'h21, 32'h00000080, 1'b1);
    op(1'b0, 32'h20, '0, 1'b0);
    op(1'b0, 32'h21, '0, 1'b1);
`endif

    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        step(1'b0, 1'b0, $urandom, $urandom, 1'b0);
      end else begin
        b = 1'b0;
`ifdef DMEM_BYTE_ACCESS_EN
        b = ($urandom_range(0, 3) == 0);
`endif
        wr = 1'($urandom_range(0, 1));
        if (widx.size() == 0) begin
          wr = 1'b1;
          b  = 1'b0;
        end
        rd = !wr || ($urandom_range(0, 3) == 0);
        if (!wr || b) idx = widx[$urandom_range(0, widx.size() - 1)];
        else          idx = int'($urandom_range(0, DEPTH - 1));
        low = 2'b00;
        if (b) low = 2'($urandom_range(0, 3));
        else if ($urandom_range(0, 7) == 0) low = 2'($urandom_range(1, 3));
        a = ($urandom() & ~32'(DEPTH * 4 - 1)) | 32'(idx * 4) | {30'b0, low};
        step(rd, wr, a, $urandom, b);
      end
    end

    step(1'b0, 1'b0, '0, '0, 1'b0);
    idle_until_free();
    repeat (4) step(1'b0, 1'b0, '0, '0, 1'b0);
    check("scoreboard_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
